// File: rtl/imem_loader.sv
// Serial boot loader: turns a length-prefixed byte frame into instruction-memory writes
// and holds the CPU while loading. Define LOADER_CHECKSUM_EN to require a trailing checksum byte.
//   state   | meaning
//   S_IDLE  | waiting for start, CPU free
//   S_LEN   | expecting length byte N (words)
//   S_DATA  | collecting the 4 bytes of the current word, LSB first
//   S_WRITE | one-cycle write strobe of the assembled word
//   S_CSUM  | expecting checksum byte (checksum build only)
//   S_DONE  | frame loaded, done held until next start
//   S_ERR   | frame rejected, error held until next start
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          idx_q, idx_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [23:0]         word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
  logic [7:0]          csum_total;
`endif

  assign accept = byte_valid && byte_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    csum_total = csum_q + byte_in;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          idx_d   = '0;
          bcnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_LEN: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = byte_in;
`endif
          if (byte_in == 8'd0) begin
            state_d = S_ERR;
          end else begin
            len_d   = byte_in;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_total;
`endif
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: word_d[7:0]   = byte_in;
            2'd1: word_d[15:8]  = byte_in;
            2'd2: word_d[23:16] = byte_in;
            default: begin
              // the top byte goes straight to the output register, so the word is complete in WRITE
              wdata_d = {byte_in, word_q};
              addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
              state_d = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        if (idx_q == 8'(len_q - 8'd1)) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
`endif
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept) begin
          state_d = (csum_total == 8'd0) ? S_DONE : S_ERR;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign byte_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign imem_we    = (state_q == S_WRITE);
  assign cpu_hold   = byte_ready || imem_we;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (BASE_ADDR 0 and 255) share one byte stream and are
// checked every cycle against a frame-level model, plus literal expectations per frame.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        rdy_o[2], we_o[2], hold_o[2], done_o[2], err_o[2];
  logic [7:0]  addr_o[2];
  logic [31:0] wdata_o[2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy_o[0]), .imem_we(we_o[0]), .imem_addr(addr_o[0]), .imem_wdata(wdata_o[0]),
    .cpu_hold(hold_o[0]), .done(done_o[0]), .error(err_o[0]));

  imem_loader #(.ADDR_W(8), .BASE_ADDR(255)) dut1 (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy_o[1]), .imem_we(we_o[1]), .imem_addr(addr_o[1]), .imem_wdata(wdata_o[1]),
    .cpu_hold(hold_o[1]), .done(done_o[1]), .error(err_o[1]));

  task automatic chk(input string name, input logic [40:0] act, input logic [40:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: state of the frame as seen from the byte stream.
  logic [7:0]  base_m[2];
  bit          m_busy[2], m_done[2], m_err[2], m_we[2], m_csum_wait[2];
  int          m_cnt[2], m_n[2], m_wr[2];
  logic [7:0]  m_sum[2], m_addr[2], m_laddr[2];
  logic [31:0] m_word[2], m_data[2], m_ldata[2];
  logic [40:0] wlog[$];

  initial begin
    base_m[0] = 8'd0;
    base_m[1] = 8'd255;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        chk($sformatf("rst_flags[%0d]", i),
            {36'd0, rdy_o[i], we_o[i], hold_o[i], done_o[i], err_o[i]}, 41'd0);
        chk($sformatf("rst_addr_data[%0d]", i), {1'b0, addr_o[i], wdata_o[i]}, 41'd0);
        m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0; m_we[i] = 0; m_csum_wait[i] = 0;
        m_cnt[i] = 0; m_n[i] = 0; m_wr[i] = 0; m_sum[i] = 8'd0;
        m_laddr[i] = 8'd0; m_ldata[i] = 32'd0; m_word[i] = 32'd0;
      end else begin
        logic [7:0] b;
        int lane;
        chk($sformatf("we[%0d]", i), {40'd0, we_o[i]}, {40'd0, m_we[i]});
        chk($sformatf("byte_ready[%0d]", i), {40'd0, rdy_o[i]}, {40'd0, m_busy[i] && !m_we[i]});
        chk($sformatf("cpu_hold[%0d]", i), {40'd0, hold_o[i]}, {40'd0, m_busy[i]});
        chk($sformatf("done_err[%0d]", i), {39'd0, done_o[i], err_o[i]}, {39'd0, m_done[i], m_err[i]});
        if (m_we[i]) begin
          chk($sformatf("wr_addr_data[%0d]", i), {1'b0, addr_o[i], wdata_o[i]}, {1'b0, m_addr[i], m_data[i]});
          wlog.push_back({i[0], addr_o[i], wdata_o[i]});
          m_laddr[i] = m_addr[i];
          m_ldata[i] = m_data[i];
          m_wr[i]++;
          m_we[i] = 0;
          if (m_wr[i] == m_n[i]) begin
`ifdef LOADER_CHECKSUM_EN
            m_csum_wait[i] = 1;
`else
            m_busy[i] = 0;
            m_done[i] = 1;
`endif
          end
        end else begin
          chk($sformatf("hold_addr_data[%0d]", i), {1'b0, addr_o[i], wdata_o[i]},
              {1'b0, m_laddr[i], m_ldata[i]});
          if (!m_busy[i]) begin
            if (start) begin
              m_busy[i] = 1; m_done[i] = 0; m_err[i] = 0; m_csum_wait[i] = 0;
              m_cnt[i] = 0; m_wr[i] = 0; m_sum[i] = 8'd0;
            end
          end else if (byte_valid) begin
            b = byte_in;
            m_sum[i] = m_sum[i] + b;
            if (m_csum_wait[i]) begin
              m_busy[i] = 0;
              if (m_sum[i] == 8'd0) m_done[i] = 1; else m_err[i] = 1;
            end else if (m_cnt[i] == 0) begin
              m_n[i] = int'(b);
              m_cnt[i] = 1;
              if (b == 8'd0) begin
                m_busy[i] = 0;
                m_err[i] = 1;
              end
            end else begin
              lane = (m_cnt[i] - 1) % 4;
              m_word[i][lane*8 +: 8] = b;
              if (lane == 3) begin
                m_we[i] = 1;
                m_addr[i] = base_m[i] + 8'((m_cnt[i] - 1) / 4);
                m_data[i] = m_word[i];
              end
              m_cnt[i]++;
            end
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    int guard;
    if (gap) begin
      byte_valid = 1'b0;
      byte_in = ~b;
      @(posedge clk); #1;
    end
    byte_in = b;
    byte_valid = 1'b1;
    acc = 0;
    guard = 0;
    while (!acc && guard < 20) begin
      @(negedge clk);
      acc = rdy_o[0];
      guard++;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    if (!acc) chk("byte_accept_timeout", 41'd0, 41'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] f[$], input bit gaps, input bit add_csum);
    logic [7:0] s;
    s = 8'd0;
    pulse_start();
    foreach (f[k]) begin
      send_byte(f[k], gaps);
      s = s + f[k];
    end
`ifdef LOADER_CHECKSUM_EN
    if (add_csum && f[0] != 8'd0) send_byte(8'(8'd0 - s), gaps);
`else
    if (add_csum && s == 8'hFF) byte_in = 8'h00;
`endif
  endtask

  task automatic wait_end(input logic exp_done, input logic exp_err);
    int guard;
    guard = 0;
    while (!(done_o[0] || err_o[0]) && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    chk("end_done_err_hold", {38'd0, done_o[0], err_o[0], hold_o[0]}, {38'd0, exp_done, exp_err, 1'b0});
    @(posedge clk); #1;
  endtask

  task automatic expect_write(input bit inst, input logic [7:0] a, input logic [31:0] d);
    if (wlog.size() == 0) begin
      chk("write_missing", 41'd0, {inst, a, d});
    end else begin
      chk("write_log", wlog.pop_front(), {inst, a, d});
    end
  endtask

  logic [7:0] fr[$];

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {39'd0, hold_o[0], rdy_o[0]}, 41'd0);

    // single word 0x00000013
    fr = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00};
    run_frame(fr, 0, 1);
    wait_end(1'b1, 1'b0);
    expect_write(1'b0, 8'h00, 32'h0000_0013);
    expect_write(1'b1, 8'hFF, 32'h0000_0013);
    chk("single_no_extra", 41'(wlog.size()), 41'd0);

    // two words with byte_valid toggling; BASE 255 wraps to 0
    fr = '{8'h02, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00};
    run_frame(fr, 1, 1);
    wait_end(1'b1, 1'b0);
    expect_write(1'b0, 8'h00, 32'h0050_0093);
    expect_write(1'b1, 8'hFF, 32'h0050_0093);
    expect_write(1'b0, 8'h01, 32'h00A0_0113);
    expect_write(1'b1, 8'h00, 32'h00A0_0113);
    chk("toggle_no_extra", 41'(wlog.size()), 41'd0);

    // zero length rejected
    fr = '{8'h00};
    run_frame(fr, 0, 1);
    wait_end(1'b0, 1'b1);
    chk("zero_len_no_write", 41'(wlog.size()), 41'd0);
    chk("zero_len_addr_held", {33'd0, addr_o[0]}, 41'h01);

    // reset mid-word, then a fresh frame
    fr = '{8'h03, 8'h11, 8'h22};
    run_frame(fr, 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_no_write", 41'(wlog.size()), 41'd0);
    fr = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
    run_frame(fr, 1, 1);
    wait_end(1'b1, 1'b0);
    expect_write(1'b0, 8'h00, 32'h1234_5678);
    expect_write(1'b1, 8'hFF, 32'h1234_5678);
    chk("midreset_no_extra", 41'(wlog.size()), 41'd0);

`ifdef LOADER_CHECKSUM_EN
    // bad checksum: word still written, frame rejected
    fr = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'hED};
    run_frame(fr, 0, 0);
    wait_end(1'b0, 1'b1);
    expect_write(1'b0, 8'h00, 32'h0000_0013);
    expect_write(1'b1, 8'hFF, 32'h0000_0013);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
